mst_wr_arb: RTL
===============

MST_WR_ARB -- requirements
Module: mst_wr_arb

Interface
REQ-001 Parameter AWIDTH, default 32, address width.
REQ-002 Parameter DWIDTH, default 32, write-data width.
REQ-003 Parameter SLAVE_NUM, default 2, number of crossbar slave ports feeding this arbiter.
REQ-004 Parameter MASTER_NUM, default 2, number of crossbar master ports (sets sel width SW = $clog2(MASTER_NUM)).
REQ-005 Parameter MASTER_ID, default 0, index of the master port this instance drives.
REQ-006 Parameter TIMEOUT_CYCLES, default 16, wait limit for m_ready (used only under REQ-027).
REQ-007 aclk  input  1  sole clock; all logic on rising edge.
REQ-008 aresetn  input  1  asynchronous, active-low reset.
REQ-009 s_req  input  SLAVE_NUM  per-slave write request level.
REQ-010 s_sel  input  SLAVE_NUM x SW  per-slave target master index.
REQ-011 s_addr  input  SLAVE_NUM x AWIDTH  per-slave write address.
REQ-012 s_wdata  input  SLAVE_NUM x DWIDTH  per-slave write data.
REQ-013 s_ack  output  SLAVE_NUM  one-cycle completion pulse to the granted slave.
REQ-014 s_err  output  SLAVE_NUM  one-cycle error pulse, coincident with s_ack on timeout.
REQ-015 m_valid, m_addr, m_wdata  output  1 / AWIDTH / DWIDTH  master-port write beat.
REQ-016 m_ready  input  1  master-port acceptance.

Function
REQ-017 Slave i is eligible when s_req[i]=1 and s_sel[i]=MASTER_ID.
REQ-018 FSM states: IDLE, BUSY, ACK.
  - IDLE: no eligible slave -> stay.
  - IDLE: any eligible slave -> grant one, register its addr/wdata, go BUSY.
  - BUSY: m_valid=1 -> on edge with m_ready=1 go ACK.
  - ACK: s_ack[grant]=1 for exactly one cycle -> IDLE.
REQ-019 Grant is round-robin: after a grant to slave g, priority order is g+1, g+2, ... mod SLAVE_NUM; after reset slave 0 has highest priority.
REQ-020 m_addr and m_wdata are registered at grant and held stable for the whole BUSY state, independent of later s_addr/s_wdata changes.
REQ-021 Latency: eligible request sampled in IDLE at edge N -> m_valid=1 in cycle N+1; m_ready=1 in cycle N+1 -> s_ack=1 in cycle N+2; IDLE in N+3; minimum 3 cycles per transfer.
REQ-022 The requester holds s_req, s_sel, s_addr and s_wdata until it samples s_ack=1 and deasserts s_req on that edge; the arbiter treats an s_req still high in the following IDLE cycle as a new request.
REQ-023 A request that drops before grant is discarded with no ack; a request that drops while BUSY or ACK does not abort the transfer.
REQ-024 Simultaneous eligible requests: exactly one grant, per REQ-019; non-granted slaves keep waiting with no ack.
REQ-025 m_valid is never high in IDLE or ACK; s_ack and s_err are one-hot or zero.

Reset
REQ-026 aresetn=0, at any time including mid-transfer: state IDLE, priority pointer to slave 0, m_valid=0, m_addr=0, m_wdata=0, s_ack=0, s_err=0, timeout counter=0; the in-flight transfer is dropped with no ack.

Configuration
REQ-027 With macro MST_WR_ARB_TIMEOUT_EN defined, a counter runs in BUSY. If m_ready stays 0 for TIMEOUT_CYCLES consecutive BUSY cycles, the FSM goes to ACK. In that ACK cycle s_ack and s_err for the granted slave are both 1, and m_valid drops.
REQ-028 Without MST_WR_ARB_TIMEOUT_EN, BUSY waits indefinitely, no counter is built, and s_err is tied to 0. The port list is identical in both builds.

Structure
REQ-029 Package xbar_pkg holds the FSM state enum (IDLE/BUSY/ACK) and a helper function for the sel width.
REQ-030 Sub-module rr_arbiter (SLAVE_NUM-wide request vector in, one-hot grant out, internal priority pointer advanced on an accept strobe) implements REQ-019; mst_wr_arb holds the FSM, data registers and timeout.

Verification
REQ-031 Single request: slave 0 sel=MASTER_ID, addr=0x100, wdata=0xA5A5A5A5, m_ready=1 -> m_valid in cycle 1 with those values, s_ack[0] in cycle 2, IDLE in cycle 3.
REQ-032 Contention: slaves 0 and 1 both request continuously, 4 transfers -> grant order 0,1,0,1; each ack is one cycle.
REQ-033 Backpressure: m_ready=0 for 5 cycles, then 1 -> m_valid held 6 cycles with stable addr/data, then one s_ack.
REQ-034 Filtering: slave 1 requests with sel≠MASTER_ID -> no m_valid, no s_ack ever.
REQ-035 Reset mid-BUSY: assert aresetn=0 while m_valid=1 -> m_valid=0 immediately (asynchronous), no s_ack; after release, the next contention grants slave 0 first.
REQ-036 Timeout (macro on, TIMEOUT_CYCLES=16): m_ready held 0 -> after 16 BUSY cycles, s_ack and s_err pulse together for one cycle, then IDLE; with the macro off, the same stimulus keeps m_valid high with no ack.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared crossbar types: write-arbiter FSM states and the select-width helper.
package xbar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } xbar_state_e;

    // Index width for n choices; a single choice still needs a 1-bit field.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request vector; the priority
// pointer moves to the slot after the winner whenever accept is strobed.
module rr_arbiter
    import xbar_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = sel_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          accept,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr_r;
    logic [N-1:0]  grant_s;
    logic [IW-1:0] idx_s;
    logic          found_s;
    logic          hit_s;
    int            cand_s;

    // Scan requests starting at the pointer; the first hit wins.
    always_comb begin
        grant_s = '0;
        idx_s   = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        cand_s  = 0;
        for (int k = 0; k < N; k++) begin
            cand_s          = (int'(ptr_r) + k) % N;
            hit_s           = !found_s && req[cand_s];
            grant_s[cand_s] = hit_s;
            idx_s           = hit_s ? IW'(cand_s) : idx_s;
            found_s         = found_s | hit_s;
        end
    end

    // Priority pointer advances past the accepted winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (accept && found_s) begin
            ptr_r <= (idx_s == IW'(N - 1)) ? '0 : idx_s + 1'b1;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign grant     = grant_s;
    assign grant_idx = idx_s;

endmodule

// File: rtl/mst_wr_arb.sv
// Per-master write arbiter: picks one eligible slave round-robin, drives one
// beat on the master port and pulses s_ack. Define MST_WR_ARB_TIMEOUT_EN to
// bound the m_ready wait and report expiry through s_err.
module mst_wr_arb
    import xbar_pkg::*;
#(
    parameter  int AWIDTH         = 32,
    parameter  int DWIDTH         = 32,
    parameter  int SLAVE_NUM      = 2,
    parameter  int MASTER_NUM     = 2,
    parameter  int MASTER_ID      = 0,
    parameter  int TIMEOUT_CYCLES = 16,
    localparam int SW             = sel_width(MASTER_NUM)
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [SLAVE_NUM-1:0]        s_req,
    input  logic [SLAVE_NUM*SW-1:0]     s_sel,
    input  logic [SLAVE_NUM*AWIDTH-1:0] s_addr,
    input  logic [SLAVE_NUM*DWIDTH-1:0] s_wdata,
    output logic [SLAVE_NUM-1:0]        s_ack,
    output logic [SLAVE_NUM-1:0]        s_err,
    output logic                        m_valid,
    output logic [AWIDTH-1:0]           m_addr,
    output logic [DWIDTH-1:0]           m_wdata,
    input  logic                        m_ready
);

    localparam int GW = sel_width(SLAVE_NUM);

    xbar_state_e           state_r;
    xbar_state_e           state_nx_s;
    logic [SLAVE_NUM-1:0]  eligible_s;
    logic [SLAVE_NUM-1:0]  arb_grant_s;
    logic [GW-1:0]         arb_idx_s;
    logic                  accept_s;
    logic                  tmo_hit_s;
    logic                  tmo_s;
    logic [SLAVE_NUM-1:0]  onehot_s;
    logic [GW-1:0]         gnt_idx_r;
    logic                  m_valid_r;
    logic [AWIDTH-1:0]     m_addr_r;
    logic [DWIDTH-1:0]     m_wdata_r;
    logic [SLAVE_NUM-1:0]  s_ack_r;

    // A slave competes only when requesting and addressed to this master.
    always_comb begin
        eligible_s = '0;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            eligible_s[i] = s_req[i] && (s_sel[i*SW +: SW] == SW'(MASTER_ID));
        end
    end

    assign accept_s = (state_r == IDLE) && (|eligible_s);
    assign onehot_s = SLAVE_NUM'(1'b1) << gnt_idx_r;

    rr_arbiter #(.N(SLAVE_NUM)) u_rr_arbiter (
        .clk       (aclk),
        .rst_n     (aresetn),
        .req       (eligible_s),
        .accept    (accept_s),
        .grant     (arb_grant_s),
        .grant_idx (arb_idx_s)
    );

    // Next-state logic; m_ready takes precedence over a coincident timeout.
    always_comb begin
        state_nx_s = state_r;
        tmo_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (|eligible_s) begin
                    state_nx_s = BUSY;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            BUSY: begin
                if (m_ready) begin
                    state_nx_s = ACK;
                end else if (tmo_hit_s) begin
                    state_nx_s = ACK;
                    tmo_s      = 1'b1;
                end else begin
                    state_nx_s = BUSY;
                end
            end
            ACK:     state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State, captured beat and registered handshake outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r   <= IDLE;
            gnt_idx_r <= '0;
            m_valid_r <= 1'b0;
            m_addr_r  <= '0;
            m_wdata_r <= '0;
            s_ack_r   <= '0;
        end else begin
            state_r   <= state_nx_s;
            m_valid_r <= (state_nx_s == BUSY);
            s_ack_r   <= (state_nx_s == ACK) ? onehot_s : '0;
            if (accept_s) begin
                gnt_idx_r <= arb_idx_s;
                m_addr_r  <= s_addr[arb_idx_s*AWIDTH +: AWIDTH];
                m_wdata_r <= s_wdata[arb_idx_s*DWIDTH +: DWIDTH];
            end else begin
                gnt_idx_r <= gnt_idx_r;
                m_addr_r  <= m_addr_r;
                m_wdata_r <= m_wdata_r;
            end
        end
    end

`ifdef MST_WR_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0]     tmo_cnt_r;
    logic [SLAVE_NUM-1:0] s_err_r;

    assign tmo_hit_s = (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));

    // Counts stalled BUSY cycles; cleared whenever the FSM leaves BUSY.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tmo_cnt_r <= '0;
            s_err_r   <= '0;
        end else begin
            s_err_r <= tmo_s ? onehot_s : '0;
            if ((state_r == BUSY) && (state_nx_s == BUSY)) begin
                tmo_cnt_r <= tmo_cnt_r + 1'b1;
            end else begin
                tmo_cnt_r <= '0;
            end
        end
    end

    assign s_err = s_err_r;
`else
    assign tmo_hit_s = 1'b0;
    assign s_err     = '0;
`endif

    assign m_valid = m_valid_r;
    assign m_addr  = m_addr_r;
    assign m_wdata = m_wdata_r;
    assign s_ack   = s_ack_r;

endmodule
